// File: rtl/neuron_pkg.sv
// Shared types and elaboration-time helpers for the mac_neuron slice:
// activation/state enums, accumulator saturation and sigmoid LUT entries.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_RELU     = 2'd0,
    ACT_SIGMOID  = 2'd1,
    ACT_IDENTITY = 2'd2
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Drop the fractional bits of the accumulator and clip into a data_w-bit signed range.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                   input int frac_w, input int data_w);
    logic signed [63:0] v, hi, lo, res;
    v  = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) begin
      res = hi;
    end else if (v < lo) begin
      res = lo;
    end else begin
      res = v;
    end
    return res;
  endfunction

  function automatic int sigmoid_entry(input int i, input int data_w,
                                       input int frac_w, input int lut_addr_w);
    real x, y;
    int  e, lim;
    x   = real'((i - 2**(lut_addr_w - 1)) * 2**(data_w - lut_addr_w)) / real'(2**frac_w);
    y   = real'(2**frac_w) / (1.0 + $exp(-x));
    e   = $rtoi(y + 0.5);
    lim = 2**(data_w - 1) - 1;
    if (e > lim) begin
      e = lim;
    end
    return e;
  endfunction

endpackage

// File: rtl/act_unit.sv
// Combinational saturation and activation stage of mac_neuron; the activation
// (ReLU, sigmoid LUT or identity) is fixed at elaboration by ACT_MODE.
module act_unit
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAC_W     = 4,
  parameter int ACC_W      = 20,
  parameter int ACT_MODE   = 0,
  parameter int LUT_ADDR_W = 5
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] act_o,
  output logic                     sat_o
);

  logic signed [63:0]       acc_ext_s, v_s, clip_s;
  logic signed [DATA_W-1:0] s_s;

  assign acc_ext_s = 64'(acc_i);
  assign v_s       = acc_ext_s >>> FRAC_W;
  assign clip_s    = sat_trunc(acc_ext_s, FRAC_W, DATA_W);
  assign s_s       = DATA_W'(clip_s);
  assign sat_o     = (clip_s != v_s);

  if (ACT_MODE == int'(ACT_RELU)) begin : g_relu
    assign act_o = s_s[DATA_W-1] ? '0 : s_s;
  end else if (ACT_MODE == int'(ACT_SIGMOID)) begin : g_sigmoid
    logic [DATA_W-1:0]     lut_s [2**LUT_ADDR_W];
    logic [LUT_ADDR_W-1:0] addr_s;
    logic                  unused_lo_s;
    for (genvar i = 0; i < 2**LUT_ADDR_W; i++) begin : g_lut
      assign lut_s[i] = DATA_W'(sigmoid_entry(i, DATA_W, FRAC_W, LUT_ADDR_W));
    end
    // Flipping the sign bit turns the signed top bits into an offset-binary table index.
    assign addr_s      = {~s_s[DATA_W-1], s_s[DATA_W-2 -: LUT_ADDR_W-1]};
    assign act_o       = lut_s[addr_s];
    assign unused_lo_s = ^s_s;
  end else begin : g_identity
    assign act_o = s_s;
  end

endmodule

// File: rtl/mac_neuron.sv
// Sequential multiply-accumulate neuron with valid/ready handshakes, loadable
// weights and bias. Define NEURON_SAT_FLAG_EN to add the sat_flag output.
module mac_neuron
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAC_W     = 4,
  parameter int NUM_IP     = 8,
  parameter int ACC_W      = 2*DATA_W + $clog2(NUM_IP) + 1,
  parameter int ACT_MODE   = 0,
  parameter int LUT_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IP*DATA_W-1:0]  x_in,
  input  logic                      wt_wr_en,
  input  logic [$clog2(NUM_IP)-1:0] wt_wr_addr,
  input  logic [DATA_W-1:0]         wt_wr_data,
  input  logic                      bias_wr_en,
  input  logic [DATA_W-1:0]         bias_wr_data,
  output logic                      wt_wr_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data
`ifdef NEURON_SAT_FLAG_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int IDX_W = $clog2(NUM_IP);

  state_e                   state_q;
  logic signed [DATA_W-1:0] x_q  [NUM_IP];
  logic signed [DATA_W-1:0] wt_q [NUM_IP];
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_init_d;
  logic [IDX_W-1:0]         idx_q;
  logic signed [2*DATA_W-1:0] prod_d;
  logic signed [DATA_W-1:0] bias_sel_d, act_s;
  logic [DATA_W-1:0]        out_data_q;
  logic                     out_valid_q, sat_s, ready_s, wt_addr_ok_s;

  assign ready_s      = (state_q == IDLE) && !rst;
  assign in_ready     = ready_s;
  assign wt_wr_ready  = ready_s;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign wt_addr_ok_s = (32'(wt_wr_addr) < NUM_IP);

  // A bias written in the accept cycle must already seed this computation.
  assign bias_sel_d = bias_wr_en ? bias_wr_data : bias_q;
  assign acc_init_d = ACC_W'(bias_sel_d) <<< FRAC_W;
  assign prod_d     = x_q[idx_q] * wt_q[idx_q];
  assign acc_d      = acc_q + ACC_W'(prod_d);

  act_unit #(
    .DATA_W    (DATA_W),
    .FRAC_W    (FRAC_W),
    .ACC_W     (ACC_W),
    .ACT_MODE  (ACT_MODE),
    .LUT_ADDR_W(LUT_ADDR_W)
  ) u_act (
    .acc_i(acc_q),
    .act_o(act_s),
    .sat_o(sat_s)
  );

`ifdef NEURON_SAT_FLAG_EN
  logic sat_q;
  assign sat_flag = sat_q;
`else
  logic unused_sat_s;
  assign unused_sat_s = sat_s;
`endif

  // Control FSM, weight bank, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef NEURON_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
      for (int i = 0; i < NUM_IP; i++) begin
        wt_q[i] <= '0;
        x_q[i]  <= '0;
      end
    end else begin
      if (ready_s && wt_wr_en && wt_addr_ok_s) begin
        wt_q[wt_wr_addr] <= wt_wr_data;
      end
      if (ready_s && bias_wr_en) begin
        bias_q <= bias_wr_data;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_IP; i++) begin
              x_q[i] <= x_in[i*DATA_W +: DATA_W];
            end
            acc_q   <= acc_init_d;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (idx_q == IDX_W'(NUM_IP - 1)) begin
            state_q <= ACT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ACT: begin
          out_data_q  <= act_s;
          out_valid_q <= 1'b1;
`ifdef NEURON_SAT_FLAG_EN
          sat_q       <= sat_s;
`endif
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
`ifdef NEURON_SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_neuron.sv
// Self-checking bench: one mac_neuron per activation mode driven in lockstep,
// results compared against an arithmetic reference model.
module tb_mac_neuron;

  localparam int DW = 8;
  localparam int NI = 8;

  logic           clk;
  logic           rst, in_valid, wt_wr_en, bias_wr_en, out_ready;
  logic [NI*DW-1:0] x_in;
  logic [2:0]     wt_wr_addr;
  logic [DW-1:0]  wt_wr_data, bias_wr_data;
  logic [2:0]     in_rdy, wr_rdy, ov;
  logic [DW-1:0]  od [3];
`ifdef NEURON_SAT_FLAG_EN
  logic [2:0]     satf;
`endif

  int n_vec = 0;
  int n_err = 0;
  int xv   [NI];
  int wt_m [NI];
  int bias_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    mac_neuron #(.ACT_MODE(m)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_rdy[m]),
      .x_in        (x_in),
      .wt_wr_en    (wt_wr_en),
      .wt_wr_addr  (wt_wr_addr),
      .wt_wr_data  (wt_wr_data),
      .bias_wr_en  (bias_wr_en),
      .bias_wr_data(bias_wr_data),
      .wt_wr_ready (wr_rdy[m]),
      .out_valid   (ov[m]),
      .out_ready   (out_ready),
      .out_data    (od[m])
`ifdef NEURON_SAT_FLAG_EN
      ,
      .sat_flag    (satf[m])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int s8(input int r);
    int t;
    t = r & 255;
    return (t >= 128) ? t - 256 : t;
  endfunction

  // Reference: Q4 dot product plus bias, floor to integer LSBs, clamp, then activation.
  function automatic int model_out(input int mode, output bit sat);
    int  sum, v, s, r;
    real xr;
    sum = bias_m * 16;
    for (int i = 0; i < NI; i++) sum += xv[i] * wt_m[i];
    v = (sum - (((sum % 16) + 16) % 16)) / 16;
    s = v;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    sat = (s != v);
    if (mode == 0) begin
      r = (s < 0) ? 0 : s;
    end else if (mode == 1) begin
      xr = real'(((s + 128) / 8 - 16) * 8) / 16.0;
      r  = $rtoi(16.0 / (1.0 + $exp(-xr)) + 0.5);
      if (r > 127) r = 127;
    end else begin
      r = s;
    end
    return r;
  endfunction

  task automatic wr(input int a, input int d, input bit is_bias);
    if (is_bias) begin
      bias_wr_en = 1'b1; bias_wr_data = 8'(d);
    end else begin
      wt_wr_en = 1'b1; wt_wr_addr = 3'(a); wt_wr_data = 8'(d);
    end
    chk("wr_ready", 32'(wr_rdy), 32'd7);
    @(posedge clk); @(negedge clk);
    wt_wr_en = 1'b0; bias_wr_en = 1'b0;
    if (is_bias) bias_m = d; else wt_m[a] = d;
  endtask

  task automatic run_vec(input string tag, input int stall, input bit hold, input bit mac_wr);
    int cnt, e;
    bit sat;
    logic [DW-1:0] exp_d [3];
    for (int i = 0; i < NI; i++) x_in[i*DW +: DW] = 8'(xv[i]);
    in_valid = 1'b1;
    chk({tag, ":in_ready"}, 32'(in_rdy), 32'd7);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; wt_wr_en = 1'b0; bias_wr_en = 1'b0;
    chk({tag, ":busy_in_ready"}, 32'(in_rdy), 32'd0);
    cnt = 1;
    if (mac_wr) begin
      wt_wr_en = 1'b1; wt_wr_addr = 3'd3; wt_wr_data = 8'h20;
      chk({tag, ":mac_wr_ready"}, 32'(wr_rdy), 32'd0);
      @(posedge clk); @(negedge clk);
      wt_wr_en = 1'b0;
      cnt = 2;
    end
    while (ov[0] !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ":latency"}, 32'(cnt), 32'd10);
    chk({tag, ":out_valid"}, 32'(ov), 32'd7);
    for (int m = 0; m < 3; m++) begin
      e = model_out(m, sat);
      exp_d[m] = 8'(e);
      chk($sformatf("%s:data_mode%0d", tag, m), 32'(od[m]), 32'(exp_d[m]));
`ifdef NEURON_SAT_FLAG_EN
      chk($sformatf("%s:sat_mode%0d", tag, m), 32'(satf[m]), 32'(sat));
`endif
    end
    if (hold) in_valid = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, ":stall_valid"}, 32'(ov), 32'd7);
      chk({tag, ":stall_in_ready"}, 32'(in_rdy), 32'd0);
      for (int m = 0; m < 3; m++)
        chk($sformatf("%s:stall_data%0d", tag, m), 32'(od[m]), 32'(exp_d[m]));
    end
    out_ready = 1'b1;
    chk({tag, ":hs_in_ready"}, 32'(in_rdy), 32'd0);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":post_valid"}, 32'(ov), 32'd0);
    chk({tag, ":post_in_ready"}, 32'(in_rdy), 32'd7);
  endtask

  initial begin
    int seen, lim, d1, d2;
    rst = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
    wt_wr_en = 1'b0; wt_wr_addr = 3'd0; wt_wr_data = 8'h00;
    bias_wr_en = 1'b0; bias_wr_data = 8'h00;
    for (int i = 0; i < NI; i++) begin xv[i] = 0; wt_m[i] = 0; end
    bias_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_rdy), 32'd0);
    chk("rst_wr_ready", 32'(wr_rdy), 32'd0);
    chk("rst_out_valid", 32'(ov), 32'd0);
    for (int m = 0; m < 3; m++) chk("rst_out_data", 32'(od[m]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_rdy), 32'd7);
    @(negedge clk);

    // Scenario 1: unit weights, x=0.5 each
    for (int i = 0; i < NI; i++) wr(i, 16, 1'b0);
    for (int i = 0; i < NI; i++) xv[i] = 8;
    run_vec("s1", 0, 1'b0, 1'b0);

    // Scenario 2: x=-1.0 each, then a negative bias pushing past -8.0
    for (int i = 0; i < NI; i++) xv[i] = -16;
    run_vec("s2", 0, 1'b0, 1'b0);
    wr(0, -16, 1'b1);
    run_vec("s2_clip", 0, 1'b0, 1'b0);

    // Scenario 3: bias only
    for (int i = 0; i < NI; i++) xv[i] = 0;
    wr(0, 24, 1'b1);
    run_vec("s3_bias", 0, 1'b0, 1'b0);
    wr(0, 0, 1'b1);
    run_vec("s3_zero", 0, 1'b0, 1'b0);

    // Scenario 4: backpressure with the next vector waiting
    for (int i = 0; i < NI; i++) xv[i] = 8;
    run_vec("s4_stall", 5, 1'b1, 1'b0);
    for (int i = 0; i < NI; i++) xv[i] = 4 * (i - 3);
    run_vec("s4_next", 0, 1'b0, 1'b0);

    // Scenario 5: weight write dropped during MAC, then applied in IDLE
    for (int i = 0; i < NI; i++) xv[i] = 8;
    run_vec("s5_drop", 0, 1'b0, 1'b1);
    wr(3, 32, 1'b0);
    run_vec("s5_idle", 0, 1'b0, 1'b0);

    // Scenario 6: reset in the middle of MAC
    for (int i = 0; i < NI; i++) x_in[i*DW +: DW] = 8'(xv[i]);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("s6_rst_wr_ready", 32'(wr_rdy), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s6_in_ready", 32'(in_rdy), 32'd7);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov !== 3'd0) seen++;
    end
    chk("s6_no_out_valid", 32'(seen), 32'd0);
    for (int i = 0; i < NI; i++) wt_m[i] = 0;
    bias_m = 0;
    run_vec("s6_after", 0, 1'b0, 1'b0);

    // Randomized rounds; odd rounds write weight 7 and bias in the accept cycle
    for (int r = 0; r < 8; r++) begin
      lim = (r < 4) ? 32 : 128;
      for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(0, 2*lim - 1)) - lim;
      for (int i = 0; i < NI - 1; i++) wr(i, int'($urandom_range(0, 2*lim - 1)) - lim, 1'b0);
      if (r % 2 == 0) begin
        wr(NI - 1, s8(int'($urandom)), 1'b0);
        wr(0, s8(int'($urandom)), 1'b1);
      end else begin
        d1 = s8(int'($urandom));
        d2 = s8(int'($urandom));
        wt_wr_en = 1'b1; wt_wr_addr = 3'd7; wt_wr_data = 8'(d1);
        bias_wr_en = 1'b1; bias_wr_data = 8'(d2);
        wt_m[NI-1] = d1;
        bias_m = d2;
      end
      run_vec($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
